// File: rtl/block_plotter.sv
`default_nettype none
// ============================================================================
// block_plotter : rasterises one BLK_W x BLK_H filled block with screen clipping
// Rev 1.0
// ============================================================================
module block_plotter #(
  parameter int BLK_W    = 4,
  parameter int BLK_H    = 4,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COL_W    = 3,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [X_W-1:0]   x,
  input  logic [Y_W-1:0]   y,
  input  logic [COL_W-1:0] colour,
  input  logic             erase,
  output logic [X_W-1:0]   x_out,
  output logic [Y_W-1:0]   y_out,
  output logic [COL_W-1:0] colour_out,
  output logic             plot,
  output logic             busy,
  output logic             done,
  output logic [X_W-1:0]   blk_x_start,
  output logic [X_W-1:0]   blk_x_end
);

  localparam int CNT_W = 4;

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_DRAW = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  localparam logic [CNT_W-1:0] c_CX_LAST = CNT_W'(BLK_W - 1);
  localparam logic [CNT_W-1:0] c_CY_LAST = CNT_W'(BLK_H - 1);
  localparam logic [X_W:0]     c_SCR_W   = (X_W + 1)'(SCREEN_W);
  localparam logic [X_W:0]     c_X_MAX   = (X_W + 1)'(SCREEN_W - 1);
  localparam logic [Y_W:0]     c_SCR_H   = (Y_W + 1)'(SCREEN_H);
  localparam logic [X_W:0]     c_BW_M1   = (X_W + 1)'(BLK_W - 1);

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cx;
  logic [CNT_W-1:0] r_cy;
  logic [X_W-1:0]   r_x;
  logic [Y_W-1:0]   r_y;
  logic [COL_W-1:0] r_col;
  logic             r_erase;
  logic [X_W-1:0]   r_bxs;
  logic [X_W-1:0]   r_bxe;

  logic [X_W:0]     w_x_sum;
  logic [Y_W:0]     w_y_sum;
  logic [X_W:0]     w_x_last;
  logic [X_W:0]     w_x_last_clip;
  logic             w_accept;

  // Sums are one bit wider so clipping sees coordinates past the screen edge.
  assign w_x_sum       = {1'b0, r_x} + (X_W + 1)'(r_cx);
  assign w_y_sum       = {1'b0, r_y} + (Y_W + 1)'(r_cy);
  assign w_x_last      = {1'b0, r_x} + c_BW_M1;
  assign w_x_last_clip = (w_x_last > c_X_MAX) ? c_X_MAX : w_x_last;
  assign w_accept      = start && (r_state != c_DRAW);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= c_IDLE;
      r_cx    <= '0;
      r_cy    <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_col   <= '0;
      r_erase <= 1'b0;
      r_bxs   <= '0;
      r_bxe   <= '0;
    end else begin
      case (r_state)
        c_DRAW: begin
          if (r_cx == c_CX_LAST) begin
            r_cx <= '0;
            if (r_cy == c_CY_LAST) begin
              r_cy    <= '0;
              r_state <= c_DONE;
              r_bxs   <= r_x;
              r_bxe   <= w_x_last_clip[X_W-1:0];
            end else begin
              r_cy <= r_cy + 1'b1;
            end
          end else begin
            r_cx <= r_cx + 1'b1;
          end
        end
        default: begin
          // IDLE and DONE both accept a new request; DONE otherwise falls back to IDLE.
          if (w_accept) begin
            r_x     <= x;
            r_y     <= y;
            r_col   <= colour;
            r_erase <= erase;
            r_cx    <= '0;
            r_cy    <= '0;
            r_state <= c_DRAW;
          end else begin
            r_state <= c_IDLE;
          end
        end
      endcase
    end
  end

  assign x_out       = w_x_sum[X_W-1:0];
  assign y_out       = w_y_sum[Y_W-1:0];
  assign colour_out  = r_erase ? '0 : r_col;
  assign plot        = (r_state == c_DRAW) && (w_x_sum < c_SCR_W) && (w_y_sum < c_SCR_H);
  assign busy        = (r_state == c_DRAW) || (r_state == c_DONE);
  assign done        = (r_state == c_DONE);
  assign blk_x_start = r_bxs;
  assign blk_x_end   = r_bxe;

endmodule
`default_nettype wire

// File: tb/tb_block_plotter.sv
`default_nettype none
// Bench for block_plotter: queue-based expectation model plus directed literal checks.
module tb_block_plotter;
  localparam int BW = 4;
  localparam int BH = 4;
  localparam int SW = 160;
  localparam int SH = 120;

  logic       clk = 1'b0;
  logic       resetn = 1'b1;
  logic       start = 1'b0;
  logic       start_b = 1'b0;
  logic [7:0] x = '0;
  logic [6:0] y = '0;
  logic [2:0] colour = '0;
  logic       erase = 1'b0;

  logic [7:0] x_out, blk_x_start, blk_x_end;
  logic [6:0] y_out;
  logic [2:0] colour_out;
  logic       plot, busy, done;

  logic [7:0] x_out_b, blk_x_start_b, blk_x_end_b;
  logic [6:0] y_out_b;
  logic [2:0] colour_out_b;
  logic       plot_b, busy_b, done_b;

  block_plotter dut (
    .clk(clk), .resetn(resetn), .start(start), .x(x), .y(y), .colour(colour), .erase(erase),
    .x_out(x_out), .y_out(y_out), .colour_out(colour_out), .plot(plot), .busy(busy),
    .done(done), .blk_x_start(blk_x_start), .blk_x_end(blk_x_end)
  );

  block_plotter #(.BLK_W(2), .BLK_H(3)) dut_b (
    .clk(clk), .resetn(resetn), .start(start_b), .x(x), .y(y), .colour(colour), .erase(erase),
    .x_out(x_out_b), .y_out(y_out_b), .colour_out(colour_out_b), .plot(plot_b), .busy(busy_b),
    .done(done_b), .blk_x_start(blk_x_start_b), .blk_x_end(blk_x_end_b)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: each accepted request becomes a list of per-cycle expected outputs.
  typedef struct {
    int x;
    int y;
    int col;
    bit plot;
    bit done;
    int bxs;
    int bxe;
  } rec_t;

  rec_t q[$];
  int m_bxs = 0;
  int m_bxe = 0;

  always @(posedge clk) begin
    if (resetn && start && q.size() == 0) begin
      int px, py;
      rec_t r;
      for (int j = 0; j < BH; j++) begin
        for (int i = 0; i < BW; i++) begin
          px     = int'(x) + i;
          py     = int'(y) + j;
          r.x    = px % 256;
          r.y    = py % 128;
          r.col  = erase ? 0 : int'(colour);
          r.plot = (px < SW) && (py < SH);
          r.done = 1'b0;
          r.bxs  = 0;
          r.bxe  = 0;
          q.push_back(r);
        end
      end
      r.plot = 1'b0;
      r.done = 1'b1;
      r.bxs  = int'(x);
      r.bxe  = (int'(x) + BW - 1 > SW - 1) ? SW - 1 : int'(x) + BW - 1;
      q.push_back(r);
    end
  end

  always @(negedge resetn) begin
    q.delete();
    m_bxs = 0;
    m_bxe = 0;
  end

  always @(negedge clk) begin
    rec_t r;
    if (!resetn) begin
      chk("rst plot", plot, 0);
      chk("rst busy", busy, 0);
      chk("rst done", done, 0);
      chk("rst x_out", x_out, 0);
      chk("rst y_out", y_out, 0);
      chk("rst colour_out", colour_out, 0);
      chk("rst blk_x_start", blk_x_start, 0);
      chk("rst blk_x_end", blk_x_end, 0);
    end else if (q.size() > 0) begin
      r = q.pop_front();
      if (r.done) begin
        m_bxs = r.bxs;
        m_bxe = r.bxe;
      end
      chk("busy", busy, 1);
      chk("done", done, r.done);
      chk("plot", plot, r.plot);
      if (!r.done) begin
        chk("x_out", x_out, r.x);
        chk("y_out", y_out, r.y);
        chk("colour_out", colour_out, r.col);
      end
      chk("blk_x_start", blk_x_start, m_bxs);
      chk("blk_x_end", blk_x_end, m_bxe);
    end else begin
      chk("idle busy", busy, 0);
      chk("idle done", done, 0);
      chk("idle plot", plot, 0);
      chk("idle blk_x_start", blk_x_start, m_bxs);
      chk("idle blk_x_end", blk_x_end, m_bxe);
    end
  end

  task automatic launch(input int xi, input int yi, input int ci, input bit ei);
    @(posedge clk);
    #1;
    x = 8'(xi); y = 7'(yi); colour = 3'(ci); erase = ei; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Returns cycle index (1 = first negedge) of done, plot count, first pixel and max plotted x.
  task automatic wait_done(output int dc, output int np, output int fx, output int fy,
                           output int fc, output int mx);
    dc = 0; np = 0; fx = -1; fy = -1; fc = -1; mx = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) begin
        fx = int'(x_out); fy = int'(y_out); fc = int'(colour_out);
      end
      if (plot) begin
        np++;
        if (int'(x_out) > mx) mx = int'(x_out);
      end
      if (done) begin
        dc = k;
        break;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int dc, np, fx, fy, fc, mx, nd;
    int bx[6];
    int by[6];
    bx = '{0, 1, 0, 1, 0, 1};
    by = '{0, 0, 1, 1, 2, 2};

    #2 resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    repeat (2) @(posedge clk);

    launch(10, 20, 5, 1'b0);
    wait_done(dc, np, fx, fy, fc, mx);
    chk("t1 done cycle", dc, 17);
    chk("t1 plot count", np, 16);
    chk("t1 first x", fx, 10);
    chk("t1 first y", fy, 20);
    chk("t1 first colour", fc, 5);
    chk("t1 blk_x_start", blk_x_start, 10);
    chk("t1 blk_x_end", blk_x_end, 13);

    launch(158, 118, 3, 1'b0);
    wait_done(dc, np, fx, fy, fc, mx);
    chk("clip done cycle", dc, 17);
    chk("clip plot count", np, 4);
    chk("clip blk_x_start", blk_x_start, 158);
    chk("clip blk_x_end", blk_x_end, 159);

    launch(40, 40, 7, 1'b1);
    wait_done(dc, np, fx, fy, fc, mx);
    chk("erase first colour", fc, 0);
    chk("erase plot count", np, 16);

    launch(10, 20, 5, 1'b0);
    repeat (4) @(posedge clk);
    #1 x = 8'd50; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(dc, np, fx, fy, fc, mx);
    chk("ignored start max x", mx, 13);
    chk("ignored start blk_x_start", blk_x_start, 10);
    x = 8'd30; y = 7'd5; colour = 3'd2; erase = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("back-to-back plot", plot, 1);
    chk("back-to-back x", x_out, 30);
    chk("back-to-back y", y_out, 5);
    wait_done(dc, np, fx, fy, fc, mx);
    chk("back-to-back done cycle", dc, 16);

    launch(10, 20, 5, 1'b0);
    repeat (8) @(negedge clk);
    #1 resetn = 1'b0;
    #1;
    chk("async rst plot", plot, 0);
    chk("async rst busy", busy, 0);
    chk("async rst done", done, 0);
    chk("async rst x_out", x_out, 0);
    @(posedge clk);
    @(posedge clk);
    #1 resetn = 1'b1;
    nd = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("no done after reset", nd, 0);
    chk("idle after reset", busy, 0);

    @(posedge clk);
    #1 x = 8'd0; y = 7'd0; colour = 3'd6; erase = 1'b0; start_b = 1'b1;
    @(posedge clk);
    #1 start_b = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k <= 6) begin
        chk("b plot", plot_b, 1);
        chk("b x_out", x_out_b, bx[k-1]);
        chk("b y_out", y_out_b, by[k-1]);
        chk("b done low", done_b, 0);
      end else begin
        chk("b done cycle 7", done_b, 1);
        chk("b blk_x_end", blk_x_end_b, 1);
      end
    end
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
